ahb_sram_ctrl: RTL and testbench
================================

Name: ahb_sram_ctrl

Overview:
- AHB-lite subordinate that owns the initiator side of the single-port synchronous SRAM interface (addr/data/wren in, q out). Compatible with sram_1024x32.
- SRAM timing it drives: write on clk edge when wren=1; read address registered on clk edge, q valid the following cycle.
- Converts AHB-lite address/data-phase transfers into SRAM cycles: zero-wait word reads and writes, wait-stated sub-word writes via read-modify-write, ERROR response for misaligned transfers.

Parameters:
ADDR_W, 10, SRAM word-address width; HADDR[ADDR_W+1:2] selects the word.

Ports:
clk  input  1  single clock; all state updates on posedge.
rst  input  1  synchronous reset, active-high.
HSEL  input  1  subordinate select.
HADDR  input  32  byte address.
HTRANS  input  2  transfer type; bit1 set = NONSEQ/SEQ.
HWRITE  input  1  1 = write.
HSIZE  input  3  0 byte, 1 half, 2 word; values above 2 treated as word.
HWDATA  input  32  write data, data phase, little-endian lanes.
HREADY  input  1  bus ready, transfer-accept qualifier.
HREADYOUT  output  1  this block's ready.
HRESP  output  1  0 OKAY, 1 ERROR.
HRDATA  output  32  read data, full word.
sram_addr  output  ADDR_W  SRAM word address.
sram_data  output  32  SRAM write data.
sram_wren  output  1  SRAM write enable.
sram_q  input  32  SRAM read data, one cycle after address.

Behaviour:
- Reset:
  - sync rst → state IDLE, HREADYOUT=1, HRESP=0, HRDATA=0, sram_wren=0, sram_data=0.
  - Captured address, size and write data cleared. Pending write/RMW dropped; no SRAM write occurs in the reset cycle.
- Accept:
  - Address phase taken when HSEL & HTRANS[1] & HREADY.
  - Captured: word addr, HADDR[1:0], HSIZE, HWRITE.
  - HSEL low or IDLE/BUSY → no transfer, OKAY zero-wait.
- Misalignment: half with HADDR[0]=1, or word with HADDR[1:0]≠0 → ERR1 then ERR2. No SRAM access.
- Read latency: sram_addr=HADDR[ADDR_W+1:2] combinationally in IDLE/RD/ERR2. Next cycle RD: HRDATA=sram_q, HREADYOUT=1. Back-to-back reads zero-wait.
- States and transitions (next transfer is decoded from the address phase accepted in the current cycle; without one, next state = IDLE):
  - IDLE: HREADYOUT=1. Next = RD / WR / RMW_RD / ERR1 per accepted transfer.
  - RD: HRDATA=sram_q, HREADYOUT=1. Next as IDLE.
  - WR (word write data phase): sram_addr=captured addr, sram_data=HWDATA, sram_wren=1, HREADYOUT=1. Next transfer accepted here: a read goes to RD_WAIT (SRAM port busy), otherwise as IDLE.
  - RD_WAIT: sram_addr=captured read addr, HREADYOUT=0 (exactly one wait state), next RD.
  - RMW_RD (byte/half write, data phase 1): sram_addr=captured addr, wren=0, HREADYOUT=0, HWDATA registered. Next RMW_WR.
  - RMW_WR: sram_data=sram_q with selected lanes replaced from the registered HWDATA. Byte → lane HADDR[1:0]; half → lanes {HADDR[1],0}+1..0. sram_wren=1, HREADYOUT=1. Next transfer handling identical to WR.
  - ERR1: HRESP=1, HREADYOUT=0. Next ERR2.
  - ERR2: HRESP=1, HREADYOUT=1. Accepts next transfer as IDLE.
- Outputs outside their listed states:
  - HRDATA=0 outside RD.
  - sram_data=0 when sram_wren=0.
  - HRESP=0 outside ERR1/ERR2.
- Address bits above ADDR_W+1 ignored (aliasing every 4 KB at default).
- Word writes overwrite all 4 lanes. Read-after-write to the same word returns new data.
- HSIZE>2 with word-aligned address: handled as word, OKAY.

Test Plan:
1. Word write 0xDEADBEEF @0x010, then IDLE, then read @0x010 → sram_wren=1 one cycle at addr 4; read HRDATA=0xDEADBEEF, zero wait states.
2. Write 0x12345678 @0x020 followed immediately by read @0x020 → WR, RD_WAIT (HREADYOUT=0 one cycle), RD HRDATA=0x12345678.
3. Word 0x11223344 @0x008, then byte write 0xAA @0x009 → two-cycle data phase (HREADYOUT 0,1), SRAM word becomes 0x1122AA44; half write 0xBEEF @0x00A → 0xBEEFAA44.
4. Halfword write @0x001 → HRESP=1 for two cycles, HREADYOUT 0 then 1, sram_wren never asserted, word 0 unchanged.
5. rst asserted in RMW_RD of byte write @0x00C (old 0xCAFEF00D) → next cycle IDLE, HREADYOUT=1, no write; later read @0x00C = 0xCAFEF00D.
6. Reads @0x000,0x004,0x1000,0x008 back-to-back after seeding → HREADYOUT stays 1; 0x1000 returns the word at 0x000 (alias).

Source files
------------

// File: rtl/ahb_sram_ctrl_if.sv
// rtl/ahb_sram_ctrl_if.sv - AHB-lite subordinate bus bundle for ahb_sram_ctrl
interface ahb_sram_ctrl_if;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic        HREADYOUT;
  logic        HRESP;
  logic [31:0] HRDATA;

  modport master (
    output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
    input  HREADYOUT, HRESP, HRDATA
  );

  modport slave (
    input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
    output HREADYOUT, HRESP, HRDATA
  );
endinterface

// File: rtl/ahb_sram_ctrl.sv
// rtl/ahb_sram_ctrl.sv - AHB-lite subordinate driving a single-port synchronous SRAM
// Zero-wait word accesses, read-modify-write for sub-word writes, two-cycle ERROR for misalignment.
module ahb_sram_ctrl #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  ahb_sram_ctrl_if.slave    ahb,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [31:0]       sram_data,
  output logic              sram_wren,
  input  logic [31:0]       sram_q
);

  typedef enum logic [2:0] {
    IDLE, RD, WR, RD_WAIT, RMW_RD, RMW_WR, ERR1, ERR2
  } state_t;

  state_t            state;
  state_t            state_nxt;
  state_t            decoded;

  logic [ADDR_W-1:0] cap_addr;
  logic [1:0]        cap_lo;
  logic [1:0]        cap_size;
  logic [31:0]       wdata_q;

  logic              can_accept;
  logic              accept;
  logic              is_word;
  logic              misaligned;
  logic [1:0]        size_norm;
  logic [3:0]        lane_en;
  logic              unused_bits;

  assign unused_bits = ^{ahb.HADDR[31:ADDR_W+2], ahb.HTRANS[0]};

  // States whose HREADYOUT is high are the only ones that end an address phase.
  assign can_accept = (state == IDLE) || (state == RD) || (state == WR) ||
                      (state == RMW_WR) || (state == ERR2);
  assign accept     = can_accept & ahb.HSEL & ahb.HTRANS[1] & ahb.HREADY;
  assign is_word    = (ahb.HSIZE >= 3'd2);
  assign size_norm  = is_word ? 2'd2 : ahb.HSIZE[1:0];
  assign misaligned = is_word ? (ahb.HADDR[1:0] != 2'b00) : (ahb.HSIZE[0] & ahb.HADDR[0]);

  always_comb begin
    decoded = IDLE;
    if (accept) begin
      if (misaligned) begin
        decoded = ERR1;
      end else if (!ahb.HWRITE) begin
        decoded = ((state == WR) || (state == RMW_WR)) ? RD_WAIT : RD;
      end else if (is_word) begin
        decoded = WR;
      end else begin
        decoded = RMW_RD;
      end
    end
  end

  always_comb begin
    lane_en = 4'b0000;
    case (cap_size)
      2'd0:    lane_en[cap_lo] = 1'b1;
      2'd1:    lane_en = cap_lo[1] ? 4'b1100 : 4'b0011;
      default: lane_en = 4'b1111;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cap_addr <= '0;
      cap_lo   <= 2'b00;
      cap_size <= 2'd0;
      wdata_q  <= 32'h0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        cap_addr <= ahb.HADDR[ADDR_W+1:2];
        cap_lo   <= ahb.HADDR[1:0];
        cap_size <= size_norm;
      end
      if (state == RMW_RD) begin
        wdata_q <= ahb.HWDATA;
      end
    end
  end

  always_comb begin
    state_nxt     = decoded;
    ahb.HREADYOUT = 1'b1;
    ahb.HRESP     = 1'b0;
    ahb.HRDATA    = 32'h0;
    sram_addr     = ahb.HADDR[ADDR_W+1:2];
    sram_data     = 32'h0;
    sram_wren     = 1'b0;
    case (state)
      RD: begin
        ahb.HRDATA = sram_q;
      end
      WR: begin
        sram_addr = cap_addr;
        sram_data = ahb.HWDATA;
        sram_wren = 1'b1;
      end
      RD_WAIT: begin
        state_nxt     = RD;
        sram_addr     = cap_addr;
        ahb.HREADYOUT = 1'b0;
      end
      RMW_RD: begin
        state_nxt     = RMW_WR;
        sram_addr     = cap_addr;
        ahb.HREADYOUT = 1'b0;
      end
      RMW_WR: begin
        sram_addr = cap_addr;
        sram_wren = 1'b1;
        for (int i = 0; i < 4; i++) begin
          sram_data[8*i +: 8] = lane_en[i] ? wdata_q[8*i +: 8] : sram_q[8*i +: 8];
        end
      end
      ERR1: begin
        state_nxt     = ERR2;
        sram_addr     = cap_addr;
        ahb.HRESP     = 1'b1;
        ahb.HREADYOUT = 1'b0;
      end
      ERR2: begin
        ahb.HRESP = 1'b1;
      end
      default: begin
      end
    endcase
    // A write pending in the reset cycle must never reach the array.
    if (rst) begin
      ahb.HREADYOUT = 1'b1;
      ahb.HRESP     = 1'b0;
      ahb.HRDATA    = 32'h0;
      sram_data     = 32'h0;
      sram_wren     = 1'b0;
    end
  end

endmodule

// File: tb/tb_ahb_sram_ctrl.sv
// tb/tb_ahb_sram_ctrl.sv - scoreboard bench for ahb_sram_ctrl
module tb_ahb_sram_ctrl;
  localparam int ADDR_W = 10;
  localparam int DEPTH  = 1 << ADDR_W;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ahb_sram_ctrl_if bus();
  logic [ADDR_W-1:0] sram_addr;
  logic [31:0]       sram_data;
  logic              sram_wren;
  logic [31:0]       sram_q = 32'h0;

  assign bus.HREADY = bus.HREADYOUT;

  ahb_sram_ctrl #(.ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .ahb       (bus),
    .sram_addr (sram_addr),
    .sram_data (sram_data),
    .sram_wren (sram_wren),
    .sram_q    (sram_q)
  );

  logic [31:0] sram_mem [DEPTH] = '{default: 32'h0};
  always @(posedge clk) begin
    if (sram_wren) sram_mem[sram_addr] <= sram_data;
    sram_q <= sram_mem[sram_addr];
  end

  typedef struct {
    bit          sel;
    logic [1:0]  trans;
    bit          wr;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [31:0] wdata;
  } op_t;

  typedef struct {
    bit          err;
    logic [31:0] rdata;
    int          waits;
  } exp_t;

  logic [31:0] ref_mem [DEPTH] = '{default: 32'h0};
  op_t  ops[$];
  exp_t sb[$];
  int   n_chk = 0;
  int   n_pass = 0;
  int   exp_wren = 0;
  int   seen_wren = 0;
  int   bad_idle_data = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Reference: a byte-addressed word memory updated with masks, waits from bus-level rules.
  task automatic model(input op_t o, input bit prev_wr, output exp_t e);
    int          word;
    int          off;
    int          nbytes;
    logic [31:0] mask;
    word   = int'((o.addr / 4) % DEPTH);
    off    = int'(o.addr % 4);
    nbytes = (o.size >= 3'd2) ? 4 : (1 << o.size);
    e.err   = (off % nbytes) != 0;
    e.rdata = 32'h0;
    e.waits = 0;
    if (e.err) begin
      e.waits = 1;
    end else if (o.wr) begin
      mask = (32'hFFFF_FFFF >> (32 - 8*nbytes)) << (8*off);
      ref_mem[word] = (ref_mem[word] & ~mask) | (o.wdata & mask);
      e.waits = (nbytes < 4) ? 1 : 0;
      exp_wren++;
    end else begin
      e.rdata = ref_mem[word];
      e.waits = prev_wr ? 1 : 0;
    end
  endtask

  task automatic add(input bit wr, input logic [31:0] addr, input logic [2:0] size,
                     input logic [31:0] wdata);
    op_t o;
    o.sel = 1'b1; o.trans = 2'b10; o.wr = wr; o.addr = addr; o.size = size; o.wdata = wdata;
    ops.push_back(o);
  endtask

  task automatic add_idle(input bit sel, input logic [1:0] trans);
    op_t o;
    o.sel = sel; o.trans = trans; o.wr = 1'b1; o.addr = 32'h10; o.size = 3'd2;
    o.wdata = 32'h0BAD_0BAD;
    ops.push_back(o);
  endtask

  task automatic bus_idle();
    bus.HSEL = 1'b0; bus.HTRANS = 2'b00; bus.HADDR = 32'h0;
    bus.HWRITE = 1'b0; bus.HSIZE = 3'd2; bus.HWDATA = 32'h0;
  endtask

  task automatic wait_ready();
    int guard;
    bit rdy;
    guard = 0;
    do begin
      @(negedge clk);
      rdy = bus.HREADYOUT;
      @(posedge clk);
      guard++;
    end while (!rdy && guard < 16);
    if (!rdy) chk("ready_timeout", 32'd0, 32'd1);
  endtask

  // Entered and left at posedge+1; the op list ends with an idle cycle to close the last data phase.
  task automatic drive_ops();
    logic [31:0] pend;
    bit          prev_wr;
    op_t         o;
    exp_t        e;
    pend    = 32'h0;
    prev_wr = 1'b0;
    add_idle(1'b0, 2'b00);
    for (int i = 0; i < ops.size(); i++) begin
      o = ops[i];
      bus.HSEL = o.sel; bus.HTRANS = o.trans; bus.HADDR = o.addr;
      bus.HSIZE = o.size; bus.HWRITE = o.wr; bus.HWDATA = pend;
      wait_ready();
      if (o.sel && o.trans[1]) begin
        model(o, prev_wr, e);
        sb.push_back(e);
        prev_wr = o.wr && !e.err;
      end else begin
        prev_wr = 1'b0;
      end
      pend = o.wdata;
      #1;
    end
    ops.delete();
    bus_idle();
  endtask

  initial begin
    bit   dp;
    int   waits;
    exp_t e;
    dp = 1'b0;
    waits = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        dp = 1'b0;
        waits = 0;
      end else begin
        if (sram_wren) seen_wren++;
        else if (sram_data !== 32'h0) bad_idle_data++;
        if (dp) begin
          if (bus.HREADYOUT) begin
            if (sb.size() == 0) begin
              chk("sb_underflow", 32'd1, 32'd0);
            end else begin
              e = sb.pop_front();
              chk("hresp", 32'(bus.HRESP), 32'(e.err));
              chk("hrdata", bus.HRDATA, e.rdata);
              chk("wait_states", 32'(waits), 32'(e.waits));
            end
            dp = 1'b0;
          end else begin
            waits++;
            if (sb.size() > 0) chk("hresp_wait", 32'(bus.HRESP), 32'(sb[0].err));
          end
        end
        if (bus.HSEL && bus.HTRANS[1] && bus.HREADYOUT) begin
          dp = 1'b1;
          waits = 0;
        end
      end
    end
  end

  initial begin
    logic [31:0] a;
    int          r;
    bus_idle();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_wren", 32'(sram_wren), 32'd0);
    #4 rst = 1'b0;
    @(negedge clk);
    chk("rst_hreadyout", 32'(bus.HREADYOUT), 32'd1);
    chk("rst_hresp", 32'(bus.HRESP), 32'd0);
    chk("rst_hrdata", bus.HRDATA, 32'h0);
    chk("rst_sram_data", sram_data, 32'h0);
    @(posedge clk);
    #1;

    add(1, 32'h010, 3'd2, 32'hDEADBEEF); add_idle(0, 2'b00); add(0, 32'h010, 3'd2, 32'h0);
    drive_ops();
    chk("t1_sram_word4", sram_mem[4], 32'hDEADBEEF);

    add(1, 32'h020, 3'd2, 32'h12345678); add(0, 32'h020, 3'd2, 32'h0);
    drive_ops();

    add(1, 32'h008, 3'd2, 32'h11223344); add(1, 32'h009, 3'd0, 32'h0000AA00);
    add(0, 32'h008, 3'd2, 32'h0);
    drive_ops();
    chk("t3_byte_merge", sram_mem[2], 32'h1122AA44);
    add(1, 32'h00A, 3'd1, 32'hBEEF0000); add(0, 32'h008, 3'd2, 32'h0);
    drive_ops();
    chk("t3_half_merge", sram_mem[2], 32'hBEEFAA44);

    add(1, 32'h001, 3'd1, 32'h0000FFFF); add(0, 32'h000, 3'd2, 32'h0);
    drive_ops();
    chk("t4_word0_kept", sram_mem[0], 32'h0);

    add(1, 32'h00C, 3'd2, 32'hCAFEF00D);
    drive_ops();
    bus.HSEL = 1'b1; bus.HTRANS = 2'b10; bus.HADDR = 32'h00C; bus.HSIZE = 3'd0; bus.HWRITE = 1'b1;
    wait_ready();
    #1;
    bus_idle();
    bus.HWDATA = 32'h000000EE;
    rst = 1'b1;
    @(negedge clk);
    chk("t5_rst_no_wren", 32'(sram_wren), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("t5_post_rst_ready", 32'(bus.HREADYOUT), 32'd1);
    chk("t5_post_rst_wren", 32'(sram_wren), 32'd0);
    @(posedge clk);
    #1;
    add(0, 32'h00C, 3'd2, 32'h0);
    drive_ops();
    chk("t5_word_kept", sram_mem[3], 32'hCAFEF00D);

    add(1, 32'h000, 3'd2, 32'hA0A1A2A3); add(1, 32'h004, 3'd2, 32'hB0B1B2B3);
    add(1, 32'h008, 3'd2, 32'hC0C1C2C3); add_idle(0, 2'b00);
    add(0, 32'h000, 3'd2, 32'h0); add(0, 32'h004, 3'd2, 32'h0);
    add(0, 32'h1000, 3'd2, 32'h0); add(0, 32'h008, 3'd2, 32'h0);
    drive_ops();

    for (int i = 0; i < 400; i++) begin
      r = int'($urandom_range(0, 9));
      if (r == 0) begin
        add_idle(1'b0, 2'b10);
      end else if (r == 1) begin
        add_idle(1'b1, 2'b01);
      end else begin
        a = ($urandom_range(0, 7) << 12) | ($urandom_range(0, 15) << 2);
        if ($urandom_range(0, 3) == 0) a = a | $urandom_range(0, 3);
        add(1'($urandom_range(0, 1)), a, 3'($urandom_range(0, 7)), $urandom);
      end
    end
    drive_ops();
    repeat (2) @(posedge clk);

    chk("wren_count", 32'(seen_wren), 32'(exp_wren));
    chk("sram_data_zero_when_idle", 32'(bad_idle_data), 32'd0);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
